// File: rtl/alu_cmd_sequencer_if.sv
// Purpose: command, ALU-drive and response signals of alu_cmd_sequencer.
//   master : the sequencer side (drives cmd_ready, ALU controls, response)
//   slave  : the environment side (command source, ALU, response consumer)
// Signals:
//   cmd_data/cmd_valid/cmd_ready      command byte stream
//   alu_in/ctrl_in/alu_out            ALU operand, control and result bytes
//   rsp_result/rsp_flags/rsp_valid/rsp_ready  response port
interface alu_cmd_sequencer_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] alu_in;
  logic [7:0] ctrl_in;
  logic [7:0] alu_out;
  logic [7:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_valid;
  logic       rsp_ready;

  modport master (
    input  cmd_data, cmd_valid, alu_out, rsp_ready,
    output cmd_ready, alu_in, ctrl_in, rsp_result, rsp_flags, rsp_valid
  );

  modport slave (
    output cmd_data, cmd_valid, alu_out, rsp_ready,
    input  cmd_ready, alu_in, ctrl_in, rsp_result, rsp_flags, rsp_valid
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose: accepts 3-byte ALU commands (ctrl, A, B), steps the downstream ALU
//   through its READ_A/READ_B/CALC/STATUS phases, captures result and flags
//   and returns them on a valid/ready response port. One command in flight.
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    alu_cmd_sequencer_if.master (command in, ALU drive, response out)
//   busy   high in every state except IDLE
// Parameters:
//   PHASE_CYCLES  cycles each ALU phase is held (>= 3, ALU has a 2-cycle lag)
// Configuration:
//   CMD_CHAIN_EN  when defined, byte0 bit1 = 1 makes a 2-byte command whose
//                 A operand is the result of the previous completed command.
module alu_cmd_sequencer #(
  parameter int unsigned PHASE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.master  bus,
  output logic                 busy
);

  localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GET_A = 3'd1;
  localparam logic [2:0] GET_B = 3'd2;
  localparam logic [2:0] DRV_A = 3'd3;
  localparam logic [2:0] DRV_B = 3'd4;
  localparam logic [2:0] CALC  = 3'd5;
  localparam logic [2:0] STAT  = 3'd6;
  localparam logic [2:0] RESP  = 3'd7;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] phase_cnt, cnt_nxt;
  logic [5:0]       op, op_nxt;          // {func[4:0], carry_in}
  logic [7:0]       opa, a_nxt;
  logic [7:0]       opb, b_nxt;
  logic [7:0]       result_nxt;
  logic [2:0]       flags_nxt;
  logic [7:0]       ctrl_nxt;
  logic [7:0]       alu_in_nxt;
  logic             cmd_ready_nxt;
  logic             rsp_valid_nxt;
  logic             busy_nxt;
  logic             cmd_fire;
  logic             rsp_fire;
  logic             phase_done;
`ifdef CMD_CHAIN_EN
  logic [7:0]       last_result, last_nxt;
`endif

  assign cmd_fire   = bus.cmd_valid & bus.cmd_ready;
  assign rsp_fire   = bus.rsp_valid & bus.rsp_ready;
  assign phase_done = (phase_cnt == CNT_LAST);

  // Next state, stored operands and registered-output next values
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = phase_cnt;
    op_nxt     = op;
    a_nxt      = opa;
    b_nxt      = opb;
    result_nxt = bus.rsp_result;
    flags_nxt  = bus.rsp_flags;
`ifdef CMD_CHAIN_EN
    last_nxt   = last_result;
`endif

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          op_nxt = bus.cmd_data[7:2];
`ifdef CMD_CHAIN_EN
          if (bus.cmd_data[1]) begin
            a_nxt     = last_result;
            state_nxt = GET_B;
          end else begin
            state_nxt = GET_A;
          end
`else
          state_nxt = GET_A;
`endif
        end
      end
      GET_A: begin
        if (cmd_fire) begin
          a_nxt     = bus.cmd_data;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (cmd_fire) begin
          b_nxt     = bus.cmd_data;
          cnt_nxt   = '0;
          state_nxt = DRV_A;
        end
      end
      DRV_A, DRV_B, CALC, STAT: begin
        if (phase_done) begin
          cnt_nxt = '0;
          case (state)
            DRV_A:   state_nxt = DRV_B;
            DRV_B:   state_nxt = CALC;
            CALC: begin
              result_nxt = bus.alu_out;
              state_nxt  = STAT;
            end
            default: begin
              flags_nxt = bus.alu_out[2:0];
              state_nxt = RESP;
            end
          endcase
        end else begin
          cnt_nxt = phase_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_fire) begin
`ifdef CMD_CHAIN_EN
          last_nxt = bus.rsp_result;
`endif
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it
    cmd_ready_nxt = (state_nxt == IDLE) || (state_nxt == GET_A) || (state_nxt == GET_B);
    rsp_valid_nxt = (state_nxt == RESP);
    busy_nxt      = (state_nxt != IDLE);

    // Outside the drive states ctrl_in keeps its last value (STATUS after a command)
    ctrl_nxt = bus.ctrl_in;
    case (state_nxt)
      DRV_A:      ctrl_nxt = {op_nxt, 2'b00};
      DRV_B:      ctrl_nxt = {op_nxt, 2'b01};
      CALC:       ctrl_nxt = {op_nxt, 2'b10};
      STAT, RESP: ctrl_nxt = {op_nxt, 2'b11};
      default:    ctrl_nxt = bus.ctrl_in;
    endcase

    alu_in_nxt = 8'h00;
    if (state_nxt == DRV_A) alu_in_nxt = a_nxt;
    if (state_nxt == DRV_B) alu_in_nxt = b_nxt;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      op             <= '0;
      opa            <= '0;
      opb            <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.ctrl_in    <= '0;
      bus.alu_in     <= '0;
      bus.cmd_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      busy           <= 1'b0;
`ifdef CMD_CHAIN_EN
      last_result    <= '0;
`endif
    end else begin
      state          <= state_nxt;
      phase_cnt      <= cnt_nxt;
      op             <= op_nxt;
      opa            <= a_nxt;
      opb            <= b_nxt;
      bus.rsp_result <= result_nxt;
      bus.rsp_flags  <= flags_nxt;
      bus.ctrl_in    <= ctrl_nxt;
      bus.alu_in     <= alu_in_nxt;
      bus.cmd_ready  <= cmd_ready_nxt;
      bus.rsp_valid  <= rsp_valid_nxt;
      busy           <= busy_nxt;
`ifdef CMD_CHAIN_EN
      last_result    <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose: randomized scoreboard bench for alu_cmd_sequencer with a pipelined
//   ALU stand-in (2-cycle lag) and directed reset/backpressure/abort cases.
module tb_alu_cmd_sequencer;

  localparam int unsigned PC      = 3;
  localparam int          LATENCY = 4 * PC + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.PHASE_CYCLES(PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int accept_cyc = 0;
  bit lat_armed  = 1'b0;
  int rsp_mode   = 2;           // 0 random, 1 held low, 2 held high
  logic [10:0] exp_q[$];        // {flags, result}
  logic [7:0]  model_last = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {carry_borrow, zero, msb, result}
  function automatic logic [10:0] alu_ref(input logic [4:0] func, input logic cin,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (func[1:0])
      2'd0:    s = 9'(a) + 9'(b) + 9'(cin);
      2'd1:    s = 9'(a) - 9'(b) - 9'(cin);
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    return {s[8], s[7:0] == 8'h00, s[7], s[7:0]};
  endfunction

  // ALU stand-in: phase register then output register (2-cycle lag)
  logic [7:0] q_ctrl, s_a, s_b;
  logic [10:0] stub_res;
  assign stub_res = alu_ref(q_ctrl[7:3], q_ctrl[2], s_a, s_b);
  always_ff @(posedge clk) begin
    q_ctrl <= bus.ctrl_in;
    if (bus.ctrl_in[1:0] == 2'b00) s_a <= bus.alu_in;
    if (bus.ctrl_in[1:0] == 2'b01) s_b <= bus.alu_in;
    case (q_ctrl[1:0])
      2'b10:   bus.alu_out <= stub_res[7:0];
      2'b11:   bus.alu_out <= {5'b0, stub_res[10:8]};
      default: bus.alu_out <= ~(s_a + s_b) ^ 8'h3C;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer readiness
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'b1;
      endcase
    end
  end

  // Response monitor: hold stability, latency, scoreboard compare
  logic       prev_valid = 1'b0;
  logic [7:0] held_res;
  logic [2:0] held_flg;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (bus.rsp_valid) begin
      if (prev_valid) begin
        check("rsp_hold_result", 32'(bus.rsp_result), 32'(held_res));
        check("rsp_hold_flags", 32'(bus.rsp_flags), 32'(held_flg));
      end else if (lat_armed) begin
        check("rsp_latency", 32'(cyc - accept_cyc), 32'(LATENCY));
        lat_armed = 1'b0;
      end
      held_res = bus.rsp_result;
      held_flg = bus.rsp_flags;
      if (bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL rsp_unexpected: got result 0x%0h flags 0x%0h, required no response", bus.rsp_result, bus.rsp_flags);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("rsp_result", 32'(bus.rsp_result), 32'(e[7:0]));
          check("rsp_flags", 32'(bus.rsp_flags), 32'(e[10:8]));
        end
        prev_valid = 1'b0;
      end else begin
        prev_valid = 1'b1;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (!bus.cmd_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
    end else if (last) begin
      accept_cyc = cyc;
      lat_armed  = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Gap cycles between bytes: the sequencer must keep waiting for more bytes
  task automatic byte_gap(input int gap);
    repeat (gap) begin
      @(negedge clk);
      check("gap_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("gap_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] a, input logic [7:0] b, input int gap);
    bit chain = 1'b0;
    logic [7:0] ea;
    logic [10:0] e;
`ifdef CMD_CHAIN_EN
    chain = b0[1];
`endif
    ea = chain ? model_last : a;
    send_byte(b0, 1'b0);
    byte_gap(gap);
    if (!chain) begin
      send_byte(a, 1'b0);
      byte_gap(gap);
    end
    send_byte(b, 1'b1);
    e = alu_ref(b0[7:3], b0[2], ea, b);
    exp_q.push_back(e);
    model_last = e[7:0];
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("idle_wait_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst_alu_in", 32'(bus.alu_in), 32'd0);
    check("rst_ctrl_in", 32'(bus.ctrl_in), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready_same_cycle", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("rel_cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back command with a full phase trace
    send_cmd(8'h0C, 8'h12, 8'h34, 0);
    for (int j = 0; j < 4 * PC; j++) begin
      logic [1:0] ph;
      logic [7:0] ea;
      ph = 2'(j / PC);
      ea = (j < PC) ? 8'h12 : ((j < 2 * PC) ? 8'h34 : 8'h00);
      @(negedge clk);
      check("trace_ctrl_in", 32'(bus.ctrl_in), 32'({6'h03, ph}));
      check("trace_alu_in", 32'(bus.alu_in), 32'(ea));
      check("trace_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    wait_idle();

    // Same command with gaps between bytes
    send_cmd(8'h0C, 8'h12, 8'h34, 5);
    wait_idle();

    // Response backpressure
    rsp_mode = 1;
    send_cmd(8'h44, 8'hF0, 8'h0F, 0);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 100) begin
        n++;
        @(negedge clk);
      end
    end
    repeat (10) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    rsp_mode = 2;
    wait_idle();

    // Reset during CALC cycle 1 aborts the command
    send_cmd(8'h08, 8'h55, 8'h22, 0);
    repeat (2 * PC + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    lat_armed  = 1'b0;
    model_last = 8'h00;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_ctrl_in", 32'(bus.ctrl_in), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_quiet_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send_cmd(8'h0C, 8'h12, 8'h34, 1);
    wait_idle();

    // Chained command, or plain 3-byte command when chaining is compiled out
    send_cmd(8'h0C, 8'h12, 8'h34, 0);
    wait_idle();
`ifdef CMD_CHAIN_EN
    send_cmd(8'h0E, 8'h00, 8'h01, 0);
`else
    send_byte(8'h0E, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("nochain_waits_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("nochain_waits_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h77, 1'b1);
    begin
      logic [10:0] e;
      e = alu_ref(5'd1, 1'b1, 8'h01, 8'h77);
      exp_q.push_back(e);
      model_last = e[7:0];
    end
`endif
    wait_idle();

    // Random commands with random gaps and consumer backpressure
    rsp_mode = 0;
    for (int i = 0; i < 40; i++) begin
      send_cmd(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end
    wait_idle();
    rsp_mode = 2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
